// File: rtl/cndm_pcie_irq_mod.sv
// Interrupt moderation: per-source pending/mask/holdoff state feeding
// registered MSI request pulses, with a shared prescaled holdoff tick.
module cndm_pcie_irq_mod #(
    parameter int unsigned IRQ_CNT   = 8,
    parameter int unsigned MSI_CNT   = 32,
    parameter int unsigned HOLDOFF_W = 16,
    parameter int unsigned PRESCALE  = 250,
    localparam int unsigned IDX_W    = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_CNT-1:0]   irq,
    input  logic                 cfg_wr_en,
    input  logic [IDX_W-1:0]     cfg_wr_idx,
    input  logic                 cfg_wr_mask,
    input  logic [HOLDOFF_W-1:0] cfg_wr_holdoff,
    output logic [31:0]          msi_irq,
    output logic [IRQ_CNT-1:0]   stat_pending,
    output logic [IRQ_CNT-1:0]   stat_mask,
    output logic [IRQ_CNT-1:0]   stat_holdoff_active
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]      ps_q;
    logic                 tick_c;

    logic [IRQ_CNT-1:0]   pending_q;
    logic [IRQ_CNT-1:0]   mask_q;
    logic [IRQ_CNT-1:0]   active_q;
    logic [HOLDOFF_W-1:0] holdoff_q [IRQ_CNT];
    logic [HOLDOFF_W-1:0] timer_q   [IRQ_CNT];
    logic [31:0]          msi_q;

    logic [IRQ_CNT-1:0]   fire_c;
    logic [IRQ_CNT-1:0]   pending_d;
    logic [IRQ_CNT-1:0]   active_d;
    logic [HOLDOFF_W-1:0] timer_d   [IRQ_CNT];
    logic [MSI_CNT-1:0]   vec_c;
    logic                 cfg_hit_c;

    // Holdoff tick fires in the cycle the prescaler wraps back to 0
    always_comb begin
        tick_c = (ps_q == PS_W'(PRESCALE - 1));
    end

    // Free-running prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else if (tick_c) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    // Per-source fire decision, pending/timer next state and vector fold
    always_comb begin
        fire_c    = '0;
        pending_d = '0;
        active_d  = '0;
        vec_c     = '0;
        for (int i = 0; i < IRQ_CNT; i++) begin
            timer_d[i]   = timer_q[i];
            fire_c[i]    = (pending_q[i] | irq[i]) & ~mask_q[i] & (timer_q[i] == '0);
            pending_d[i] = (pending_q[i] | irq[i]) & ~fire_c[i];
            if (fire_c[i]) begin
                timer_d[i] = holdoff_q[i];
            end else if (tick_c && (timer_q[i] != '0)) begin
                timer_d[i] = timer_q[i] - HOLDOFF_W'(1);
            end
            active_d[i] = (timer_d[i] != '0);
            if (fire_c[i]) begin
                vec_c[i % MSI_CNT] = 1'b1;
            end
        end
    end

    // Out-of-range indices are dropped
    always_comb begin
        cfg_hit_c = cfg_wr_en && (32'(cfg_wr_idx) < IRQ_CNT);
    end

    // Source state and MSI output registers; config lands after fire uses old values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '1;
            active_q  <= '0;
            msi_q     <= '0;
            for (int i = 0; i < IRQ_CNT; i++) begin
                timer_q[i]   <= '0;
                holdoff_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            msi_q     <= 32'(vec_c);
            for (int i = 0; i < IRQ_CNT; i++) begin
                timer_q[i] <= timer_d[i];
                if (cfg_hit_c && (cfg_wr_idx == IDX_W'(i))) begin
                    mask_q[i]    <= cfg_wr_mask;
                    holdoff_q[i] <= cfg_wr_holdoff;
                end
            end
        end
    end

    assign msi_irq             = msi_q;
    assign stat_pending        = pending_q;
    assign stat_mask           = mask_q;
    assign stat_holdoff_active = active_q;

endmodule

// File: tb/tb_cndm_pcie_irq_mod.sv
// Bench for cndm_pcie_irq_mod: directed table, corner sequences, random run vs model.
module tb_cndm_pcie_irq_mod;

    localparam int NI = 6;
    localparam int NM = 4;
    localparam int HW = 8;
    localparam int PS = 4;

    logic          clk;
    logic          rst;
    logic [NI-1:0] irq;
    logic          cfg_wr_en;
    logic [2:0]    cfg_wr_idx;
    logic          cfg_wr_mask;
    logic [HW-1:0] cfg_wr_holdoff;
    logic [31:0]   msi_irq;
    logic [NI-1:0] stat_pending;
    logic [NI-1:0] stat_mask;
    logic [NI-1:0] stat_holdoff_active;

    cndm_pcie_irq_mod #(
        .IRQ_CNT(NI), .MSI_CNT(NM), .HOLDOFF_W(HW), .PRESCALE(PS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq(irq),
        .cfg_wr_en(cfg_wr_en),
        .cfg_wr_idx(cfg_wr_idx),
        .cfg_wr_mask(cfg_wr_mask),
        .cfg_wr_holdoff(cfg_wr_holdoff),
        .msi_irq(msi_irq),
        .stat_pending(stat_pending),
        .stat_mask(stat_mask),
        .stat_holdoff_active(stat_holdoff_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural reference state, one entry per source
    int          m_pend [NI];
    int          m_mask [NI];
    int          m_hold [NI];
    int          m_tmr  [NI];
    int          m_ps;
    logic [31:0] m_msi;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pend[i] = 0; m_mask[i] = 1; m_hold[i] = 0; m_tmr[i] = 0;
        end
        m_ps  = 0;
        m_msi = '0;
    endtask

    // One clock of the rules: fire on (pending|event), unmasked, timer idle
    task automatic model_step();
        int np [NI];
        int nt [NI];
        bit tick;
        logic [31:0] nm;
        tick = (m_ps == PS - 1);
        nm = '0;
        for (int i = 0; i < NI; i++) begin
            bit ev;
            bit fire;
            ev   = (m_pend[i] != 0) || irq[i];
            fire = ev && (m_mask[i] == 0) && (m_tmr[i] == 0);
            if (fire) nm[i % NM] = 1'b1;
            np[i] = (ev && !fire) ? 1 : 0;
            if (fire)                          nt[i] = m_hold[i];
            else if (tick && m_tmr[i] > 0)     nt[i] = m_tmr[i] - 1;
            else                               nt[i] = m_tmr[i];
        end
        for (int i = 0; i < NI; i++) begin
            m_pend[i] = np[i];
            m_tmr[i]  = nt[i];
        end
        if (cfg_wr_en && int'(cfg_wr_idx) < NI) begin
            m_mask[int'(cfg_wr_idx)] = cfg_wr_mask ? 1 : 0;
            m_hold[int'(cfg_wr_idx)] = int'(cfg_wr_holdoff);
        end
        m_msi = nm;
        m_ps  = (m_ps + 1) % PS;
    endtask

    task automatic cmp_model(input string tag);
        logic [31:0] p, m, a;
        p = '0; m = '0; a = '0;
        for (int i = 0; i < NI; i++) begin
            p[i] = (m_pend[i] != 0);
            m[i] = (m_mask[i] != 0);
            a[i] = (m_tmr[i] != 0);
        end
        chk({tag, ".msi"},  msi_irq, m_msi);
        chk({tag, ".pend"}, 32'(stat_pending), p);
        chk({tag, ".mask"}, 32'(stat_mask), m);
        chk({tag, ".act"},  32'(stat_holdoff_active), a);
    endtask

    // Advance one clock; inputs already applied, outputs sampled 1 time unit after edge
    task automatic step(input bit use_model, input string tag);
        model_step();
        @(posedge clk);
        #1;
        if (use_model) cmp_model(tag);
    endtask

    task automatic drive(input logic [NI-1:0] i_irq, input logic wr, input logic [2:0] idx,
                         input logic wm, input logic [HW-1:0] wh);
        irq = i_irq; cfg_wr_en = wr; cfg_wr_idx = idx; cfg_wr_mask = wm; cfg_wr_holdoff = wh;
    endtask

    typedef struct {
        logic [NI-1:0] irq;
        logic          wr;
        logic [2:0]    idx;
        logic          wm;
        logic [HW-1:0] wh;
        logic [31:0]   msi;
        logic [NI-1:0] pend;
        logic [NI-1:0] mask;
    } vec_t;

    vec_t tbl [12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int pulses;
        int pos;
        tbl[0]  = '{6'h00, 1'b1, 3'd0, 1'b0, 8'd0, 32'h0, 6'h00, 6'h3E};
        tbl[1]  = '{6'h01, 1'b0, 3'd0, 1'b0, 8'd0, 32'h1, 6'h00, 6'h3E};
        tbl[2]  = '{6'h00, 1'b0, 3'd0, 1'b0, 8'd0, 32'h0, 6'h00, 6'h3E};
        tbl[3]  = '{6'h04, 1'b0, 3'd0, 1'b0, 8'd0, 32'h0, 6'h04, 6'h3E};
        tbl[4]  = '{6'h00, 1'b1, 3'd2, 1'b0, 8'd0, 32'h0, 6'h04, 6'h3A};
        tbl[5]  = '{6'h00, 1'b0, 3'd0, 1'b0, 8'd0, 32'h4, 6'h00, 6'h3A};
        tbl[6]  = '{6'h00, 1'b1, 3'd1, 1'b0, 8'd0, 32'h0, 6'h00, 6'h38};
        tbl[7]  = '{6'h00, 1'b1, 3'd5, 1'b0, 8'd0, 32'h0, 6'h00, 6'h18};
        tbl[8]  = '{6'h22, 1'b0, 3'd0, 1'b0, 8'd0, 32'h2, 6'h00, 6'h18};
        tbl[9]  = '{6'h08, 1'b0, 3'd0, 1'b0, 8'd0, 32'h0, 6'h08, 6'h18};
        tbl[10] = '{6'h00, 1'b1, 3'd7, 1'b0, 8'd0, 32'h0, 6'h08, 6'h18};
        tbl[11] = '{6'h00, 1'b1, 3'd6, 1'b0, 8'd0, 32'h0, 6'h08, 6'h18};

        rst = 1'b1;
        drive('0, 1'b0, 3'd0, 1'b0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.msi",  msi_irq, 32'h0);
        chk("rst.pend", 32'(stat_pending), 32'h0);
        chk("rst.mask", 32'(stat_mask), 32'h3F);
        chk("rst.act",  32'(stat_holdoff_active), 32'h0);
        rst = 1'b0;

        // Directed table: unmask, single fire, masked pending, shared vector, bad index
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].irq, tbl[k].wr, tbl[k].idx, tbl[k].wm, tbl[k].wh);
            step(1'b0, "tbl");
            chk($sformatf("tbl%0d.msi", k),  msi_irq, tbl[k].msi);
            chk($sformatf("tbl%0d.pend", k), 32'(stat_pending), 32'(tbl[k].pend));
            chk($sformatf("tbl%0d.mask", k), 32'(stat_mask), 32'(tbl[k].mask));
            chk($sformatf("tbl%0d.act", k),  32'(stat_holdoff_active), 32'h0);
        end

        // Holdoff 0, event held 5 cycles: a pulse every cycle
        drive('0, 1'b1, 3'd3, 1'b0, 8'd0);
        step(1'b1, "hold5.cfg");
        for (int k = 0; k < 5; k++) begin
            drive(6'h08, 1'b0, 3'd0, 1'b0, '0);
            step(1'b1, "hold5");
            chk($sformatf("hold5.msi%0d", k), msi_irq, 32'h8);
            chk($sformatf("hold5.pend%0d", k), 32'(stat_pending[3]), 32'h0);
        end
        drive('0, 1'b0, 3'd0, 1'b0, '0);
        step(1'b1, "hold5.end");
        chk("hold5.after", msi_irq, 32'h0);

        // Holdoff 3 ticks: events at 0,2,5 give one immediate and one coalesced fire
        drive('0, 1'b1, 3'd1, 1'b0, 8'd3);
        step(1'b1, "coal.cfg");
        drive(6'h02, 1'b0, 3'd0, 1'b0, '0);
        step(1'b1, "coal.first");
        chk("coal.first.msi", msi_irq, 32'h2);
        chk("coal.first.act", 32'(stat_holdoff_active[1]), 32'h1);
        pulses = 0;
        pos = -1;
        for (int k = 1; k <= 20; k++) begin
            drive((k == 2 || k == 5) ? 6'h02 : 6'h00, 1'b0, 3'd0, 1'b0, '0);
            step(1'b1, "coal");
            if (msi_irq[1]) begin
                pulses++;
                pos = k;
            end
        end
        chk("coal.pulses", 32'(pulses), 32'd1);
        chk("coal.pos.inrange", 32'((pos >= 10) && (pos <= 13)), 32'd1);
        chk("coal.pend", 32'(stat_pending[1]), 32'h0);

        // Reset in the middle of a holdoff with pending set
        drive('0, 1'b1, 3'd4, 1'b0, 8'd5);
        step(1'b1, "rsth.cfg");
        drive(6'h10, 1'b0, 3'd0, 1'b0, '0);
        step(1'b1, "rsth.fire");
        chk("rsth.fire.msi", msi_irq, 32'h1);
        drive('0, 1'b0, 3'd0, 1'b0, '0);
        step(1'b1, "rsth.idle");
        drive(6'h10, 1'b0, 3'd0, 1'b0, '0);
        step(1'b1, "rsth.ev");
        drive('0, 1'b0, 3'd0, 1'b0, '0);
        chk("rsth.pend.before", 32'(stat_pending[4]), 32'h1);
        chk("rsth.act.before", 32'(stat_holdoff_active[4]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rsth.msi",  msi_irq, 32'h0);
        chk("rsth.pend", 32'(stat_pending), 32'h0);
        chk("rsth.mask", 32'(stat_mask), 32'h3F);
        chk("rsth.act",  32'(stat_holdoff_active), 32'h0);
        irq = 6'h3F;
        repeat (2) @(posedge clk);
        #1;
        irq = '0;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, "rsth.post");
            chk($sformatf("rsth.post%0d.msi", k), msi_irq, 32'h0);
        end

        // Randomized traffic and config against the reference model
        for (int k = 0; k < 800; k++) begin
            logic [31:0] r;
            r = $urandom;
            irq = r[5:0] & r[11:6];
            cfg_wr_en = ($urandom_range(0, 7) == 0);
            cfg_wr_idx = 3'($urandom_range(0, 7));
            cfg_wr_mask = ($urandom_range(0, 3) == 0);
            cfg_wr_holdoff = HW'($urandom_range(0, 4));
            step(1'b1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
